// File: rtl/ifns_rx_buffer_22.sv
// Receive-side elastic buffer behind the IFNS decoder: strobe re-timing, show-ahead FIFO, sticky overflow.
// Optional dropped-word counter enabled by defining IFNS_RXBUF_OVF_CNT_EN.
module ifns_rx_buffer_22 #(
  parameter int DATA_W = 22,
  parameter int DEPTH  = 4,
  parameter int LAT    = 1
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        din,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef IFNS_RXBUF_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [LAT-1:0]    valid_sr_reg;
  logic [LAT-1:0]    valid_sr_next;
  logic              wr_en;
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       wr_ptr_next;
  logic [AW:0]       rd_ptr_reg;
  logic [AW:0]       rd_ptr_next;
  logic [AW:0]       level_reg;
  logic [AW:0]       level_next;
  logic              overflow_reg;
  logic              overflow_next;
  logic              empty;
  logic              full;
  logic              pop;
  logic              wr_accept;
  logic              drop;
  logic [DATA_W-1:0] mem [DEPTH];

  // Delay line mirrors the decoder pipeline so wr_en lines up with din.
  generate
    for (genvar gi = 0; gi < LAT; gi++) begin : g_dly
      if (gi == 0) begin : g_first
        assign valid_sr_next[gi] = in_valid;
      end else begin : g_rest
        assign valid_sr_next[gi] = valid_sr_reg[gi-1];
      end
    end
  endgenerate

  assign wr_en = valid_sr_reg[LAT-1];

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign pop       = !empty && out_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign wr_accept = wr_en && (!full || pop);
  assign drop      = wr_en && full && !pop;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    overflow_next = overflow_reg;
    if (wr_accept) wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
    if (pop)       rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
    if (wr_accept && !pop)      level_next = level_reg + (AW+1)'(1);
    else if (!wr_accept && pop) level_next = level_reg - (AW+1)'(1);
    if (drop)         overflow_next = 1'b1;
    else if (ovf_clr) overflow_next = 1'b0;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      valid_sr_reg <= valid_sr_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge clock) begin
    if (wr_accept) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign level     = level_reg;
  assign overflow  = overflow_reg;

`ifdef IFNS_RXBUF_OVF_CNT_EN
  logic [7:0] ovf_cnt_reg;
  logic [7:0] ovf_cnt_next;

  // Counting a drop wins over a clear in the same cycle.
  always_comb begin
    ovf_cnt_next = ovf_cnt_reg;
    if (drop) begin
      if (ovf_clr)                  ovf_cnt_next = 8'd1;
      else if (ovf_cnt_reg != 8'hFF) ovf_cnt_next = ovf_cnt_reg + 8'd1;
    end else if (ovf_clr) begin
      ovf_cnt_next = 8'd0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) ovf_cnt_reg <= 8'd0;
    else        ovf_cnt_reg <= ovf_cnt_next;
  end

  assign ovf_cnt = ovf_cnt_reg;
`endif

endmodule

// File: tb/tb_ifns_rx_buffer_22.sv
// Directed self-checking bench for ifns_rx_buffer_22 (DATA_W=22, DEPTH=4, LAT=1).
module tb_ifns_rx_buffer_22;

  logic        clock;
  logic        rst_n;
  logic        in_valid;
  logic [21:0] din;
  logic        out_valid;
  logic [21:0] out_data;
  logic        out_ready;
  logic [2:0]  level;
  logic        overflow;
  logic        ovf_clr;
`ifdef IFNS_RXBUF_OVF_CNT_EN
  logic [7:0]  ovf_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [21:0] din_pend;

  ifns_rx_buffer_22 #(.DATA_W(22), .DEPTH(4), .LAT(1)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din       (din),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
`ifdef IFNS_RXBUF_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive in_valid now, present the word of the previous strobe on din
  // (decoder latency 1), then sample #1 after the edge.
  task automatic cyc(input logic iv, input logic [21:0] word, input logic rdy, input logic clr);
    in_valid  = iv;
    din       = din_pend;
    out_ready = rdy;
    ovf_clr   = clr;
    din_pend  = word;
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0; ovf_clr = 1'b0; din_pend = '0;

    // Reset state, checked before any clock edge.
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {10'd0, out_data}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clock); #1;
    rst_n = 1'b1;

    // Single word.
    cyc(1'b1, 22'h2AAAA, 1'b0, 1'b0);
    check("single_not_yet", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 22'h0, 1'b0, 1'b0);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_data", {10'd0, out_data}, 32'h2AAAA);
    check("single_level", {29'd0, level}, 32'd1);
    cyc(1'b0, 22'h0, 1'b1, 1'b0);
    check("single_pop_level", {29'd0, level}, 32'd0);
    check("single_pop_valid", {31'd0, out_valid}, 32'd0);
    check("single_pop_data", {10'd0, out_data}, 32'd0);

    // Overflow: five words into four slots with no consumer.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 22'(i), 1'b0, 1'b0);
    check("ovf_full_level", {29'd0, level}, 32'd4);
    check("ovf_not_yet", {31'd0, overflow}, 32'd0);
    cyc(1'b0, 22'h0, 1'b0, 1'b0);
    check("ovf_level", {29'd0, level}, 32'd4);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
`ifdef IFNS_RXBUF_OVF_CNT_EN
    check("ovf_cnt_one", {24'd0, ovf_cnt}, 32'd1);
`endif
    for (int i = 1; i <= 4; i++) begin
      check("ovf_drain_data", {10'd0, out_data}, 32'(i));
      cyc(1'b0, 22'h0, 1'b1, 1'b0);
    end
    check("ovf_drained_level", {29'd0, level}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    cyc(1'b0, 22'h0, 1'b0, 1'b1);
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
`ifdef IFNS_RXBUF_OVF_CNT_EN
    check("ovf_cnt_cleared", {24'd0, ovf_cnt}, 32'd0);
`endif

    // Full with simultaneous pop and write.
    cyc(1'b1, 22'h0000A1, 1'b0, 1'b0);
    cyc(1'b1, 22'h0000A2, 1'b0, 1'b0);
    cyc(1'b1, 22'h0000A3, 1'b0, 1'b0);
    cyc(1'b1, 22'h0000A4, 1'b0, 1'b0);
    cyc(1'b1, 22'h3FFFFF, 1'b0, 1'b0);
    check("fp_full_level", {29'd0, level}, 32'd4);
    check("fp_head", {10'd0, out_data}, 32'hA1);
    cyc(1'b0, 22'h0, 1'b1, 1'b0);
    check("fp_level_kept", {29'd0, level}, 32'd4);
    check("fp_no_ovf", {31'd0, overflow}, 32'd0);
    check("fp_out1", {10'd0, out_data}, 32'hA2);
    cyc(1'b0, 22'h0, 1'b1, 1'b0);
    check("fp_out2", {10'd0, out_data}, 32'hA3);
    cyc(1'b0, 22'h0, 1'b1, 1'b0);
    check("fp_out3", {10'd0, out_data}, 32'hA4);
    cyc(1'b0, 22'h0, 1'b1, 1'b0);
    check("fp_out4", {10'd0, out_data}, 32'h3FFFFF);
    cyc(1'b0, 22'h0, 1'b1, 1'b0);
    check("fp_empty_level", {29'd0, level}, 32'd0);

    // Streaming ten words with pointer wrap.
    for (int i = 0; i <= 10; i++) begin
      cyc(i < 10, 22'(32'h10 + i), 1'b1, 1'b0);
      if (i >= 1) begin
        check("stream_valid", {31'd0, out_valid}, 32'd1);
        check("stream_data", {10'd0, out_data}, 32'h10 + 32'(i) - 32'd1);
        check("stream_level", {29'd0, level}, 32'd1);
      end
    end
    cyc(1'b0, 22'h0, 1'b1, 1'b0);
    check("stream_end_valid", {31'd0, out_valid}, 32'd0);
    check("stream_end_level", {29'd0, level}, 32'd0);

    // Reset mid-operation: three buffered, one in the delay line.
    cyc(1'b1, 22'h0000B1, 1'b0, 1'b0);
    cyc(1'b1, 22'h0000B2, 1'b0, 1'b0);
    cyc(1'b1, 22'h0000B3, 1'b0, 1'b0);
    cyc(1'b1, 22'h0000B4, 1'b0, 1'b0);
    check("mid_level_pre", {29'd0, level}, 32'd3);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", {29'd0, level}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {10'd0, out_data}, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 22'h0, 1'b1, 1'b0);
      check("mid_post_valid", {31'd0, out_valid}, 32'd0);
      check("mid_post_level", {29'd0, level}, 32'd0);
    end
    cyc(1'b1, 22'h0000C1, 1'b0, 1'b0);
    cyc(1'b0, 22'h0, 1'b0, 1'b0);
    check("mid_new_valid", {31'd0, out_valid}, 32'd1);
    check("mid_new_data", {10'd0, out_data}, 32'hC1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
